// File: rtl/mprj_io_cfg_sequencer.sv
// Shadow-register bank for user I/O pad configuration, plus a sequencer
// that serialises every shadow into the pad configuration chain.
module mprj_io_cfg_sequencer #(
   parameter int TOTAL_PADS = 38,
   parameter int CFG_BITS   = 5,
   parameter int CLK_DIV    = 2
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_i,
   input  logic                cfg_we,
   input  logic [5:0]          cfg_addr,
   input  logic [CFG_BITS-1:0] cfg_wdata,
   output logic [CFG_BITS-1:0] cfg_rdata,
   output logic                cfg_wr_err,
   input  logic                xfer_start,
   output logic                xfer_busy,
   output logic                xfer_done,
   output logic                serial_clock,
   output logic                serial_data,
   output logic                serial_load
);

   localparam int N     = TOTAL_PADS * CFG_BITS;
   localparam int CNT_W = $clog2(N + 1);
   localparam int DIV_W = $clog2(CLK_DIV + 1);
   localparam int BIT_W = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;

   // Input-only pad: oeb=1, inp_dis=0, dm=001
   localparam logic [CFG_BITS-1:0] RST_VAL  = CFG_BITS'(5'b1_0_001);
   localparam logic [5:0]          LAST_PAD = 6'(TOTAL_PADS - 1);
   localparam logic [BIT_W-1:0]    MSB_BIT  = BIT_W'(CFG_BITS - 1);
   localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0]    CNT_INIT = CNT_W'(N);
   localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);

   typedef enum logic [2:0] {StIdle, StShiftLo, StShiftHi, StLoad, StDone} state_t;

   logic [CFG_BITS-1:0] shadow [TOTAL_PADS];
   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic [DIV_W-1:0]    div;
   logic [5:0]          pad;
   logic [BIT_W-1:0]    bitsel;
   logic                shift_en;
   logic                addr_ok;

   assign addr_ok = ({1'b0, cfg_addr} < 7'(TOTAL_PADS));

   // Read port: out-of-range addresses read as zero
   always_comb begin
      cfg_rdata = '0;
      if (addr_ok) cfg_rdata = shadow[cfg_addr];
   end

   // Shadows cannot change while busy, so a direct read is safe mid-transfer
   assign serial_data = shift_en ? shadow[pad][bitsel] : 1'b0;

   // Shadow writes; writes during a transfer are dropped and flagged
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         for (int i = 0; i < TOTAL_PADS; i++) shadow[i] <= RST_VAL;
         cfg_wr_err <= 1'b0;
      end else begin
         cfg_wr_err <= cfg_we && xfer_busy;
         if (cfg_we && !xfer_busy && addr_ok) shadow[cfg_addr] <= cfg_wdata;
      end
   end

   // Transfer sequencer with registered chain outputs
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state        <= StIdle;
         cnt          <= '0;
         div          <= '0;
         pad          <= '0;
         bitsel       <= '0;
         shift_en     <= 1'b0;
         xfer_busy    <= 1'b0;
         xfer_done    <= 1'b0;
         serial_clock <= 1'b0;
         serial_load  <= 1'b0;
      end else begin
         unique case (state)
            StIdle: begin
               if (xfer_start) begin
                  state     <= StShiftLo;
                  cnt       <= CNT_INIT;
                  div       <= '0;
                  pad       <= LAST_PAD;
                  bitsel    <= MSB_BIT;
                  shift_en  <= 1'b1;
                  xfer_busy <= 1'b1;
               end
            end
            StShiftLo: begin
               if (div == DIV_LAST) begin
                  div          <= '0;
                  serial_clock <= 1'b1;
                  state        <= StShiftHi;
               end else begin
                  div <= div + 1'b1;
               end
            end
            StShiftHi: begin
               if (div == DIV_LAST) begin
                  div          <= '0;
                  serial_clock <= 1'b0;
                  cnt          <= cnt - 1'b1;
                  if (cnt == CNT_ONE) begin
                     shift_en    <= 1'b0;
                     serial_load <= 1'b1;
                     state       <= StLoad;
                  end else begin
                     // Next bit: MSB-first within a pad, pads walk downwards
                     if (bitsel == '0) begin
                        bitsel <= MSB_BIT;
                        pad    <= pad - 1'b1;
                     end else begin
                        bitsel <= bitsel - 1'b1;
                     end
                     state <= StShiftLo;
                  end
               end else begin
                  div <= div + 1'b1;
               end
            end
            StLoad: begin
               if (div == DIV_LAST) begin
                  div         <= '0;
                  serial_load <= 1'b0;
                  xfer_done   <= 1'b1;
                  state       <= StDone;
               end else begin
                  div <= div + 1'b1;
               end
            end
            StDone: begin
               xfer_done <= 1'b0;
               xfer_busy <= 1'b0;
               state     <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_mprj_io_cfg_sequencer.sv
// Directed bench for mprj_io_cfg_sequencer with a simple chain capture model.
module tb_mprj_io_cfg_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       cfg_we;
   logic [5:0] cfg_addr;
   logic [4:0] cfg_wdata;
   logic [4:0] cfg_rdata;
   logic       cfg_wr_err;
   logic       xfer_start;
   logic       xfer_busy;
   logic       xfer_done;
   logic       serial_clock;
   logic       serial_data;
   logic       serial_load;

   int errors = 0;
   int checks = 0;

   // Chain model results
   logic cap [0:255];
   int   ncap, nload, nerr, ndone, done_at;
   logic rst_sclk, rst_busy;

   always #5 clk = ~clk;

   mprj_io_cfg_sequencer dut (
      .wb_clk_i    (clk),
      .wb_rst_i    (rst),
      .cfg_we      (cfg_we),
      .cfg_addr    (cfg_addr),
      .cfg_wdata   (cfg_wdata),
      .cfg_rdata   (cfg_rdata),
      .cfg_wr_err  (cfg_wr_err),
      .xfer_start  (xfer_start),
      .xfer_busy   (xfer_busy),
      .xfer_done   (xfer_done),
      .serial_clock(serial_clock),
      .serial_data (serial_data),
      .serial_load (serial_load)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic rd(input int a, input logic [4:0] exp);
      @(negedge clk);
      cfg_addr = 6'(a);
      #1;
      check($sformatf("rdata[%0d]", a), {27'd0, cfg_rdata}, {27'd0, exp});
   endtask

   task automatic wr(input int a, input logic [4:0] d);
      @(negedge clk);
      cfg_we    = 1'b1;
      cfg_addr  = 6'(a);
      cfg_wdata = d;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   function automatic logic [4:0] grab(input int base);
      return {cap[base], cap[base+1], cap[base+2], cap[base+3], cap[base+4]};
   endfunction

   // Caller has already driven xfer_start (and optionally cfg_we) before the start edge.
   // Cycle k=1 is the first cycle after the start edge.
   task automatic run_xfer(input int we_at, input int we_addr, input logic [4:0] we_data,
                           input int start_at, input int rst_at);
      logic prev = 1'b0;
      ncap = 0; nload = 0; nerr = 0; ndone = 0; done_at = 0;
      rst_sclk = 1'bx; rst_busy = 1'bx;
      for (int i = 0; i < 256; i++) cap[i] = 1'b0;
      for (int k = 1; k <= 780; k++) begin
         @(negedge clk);
         if (serial_clock && !prev) begin
            if (ncap < 256) cap[ncap] = serial_data;
            ncap++;
         end
         prev = serial_clock;
         if (serial_load) nload++;
         if (cfg_wr_err) nerr++;
         if (xfer_done) begin
            ndone++;
            if (done_at == 0) done_at = k;
         end
         if (rst_at != 0 && k == rst_at + 1) begin
            rst_sclk = serial_clock;
            rst_busy = xfer_busy;
         end
         xfer_start = (k == start_at);
         cfg_we     = (k == we_at);
         cfg_addr   = 6'(we_addr);
         cfg_wdata  = we_data;
         rst        = (rst_at != 0 && k == rst_at);
      end
   endtask

   initial begin
      rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; xfer_start = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_outs", {26'd0, xfer_busy, xfer_done, serial_clock, serial_data,
                         serial_load, cfg_wr_err}, 32'd0);
      #1;
      check("rst_rdata0", {27'd0, cfg_rdata}, 32'h11);
      rst = 1'b0;

      // Reset values and out-of-range read
      for (int a = 0; a < 38; a++) rd(a, 5'h11);
      rd(40, 5'h00);

      // Out-of-range write is silently ignored
      wr(40, 5'h1F);
      check("oor_wr_err", {31'd0, cfg_wr_err}, 32'd0);
      rd(40, 5'h00);

      wr(0, 5'h0A);
      wr(37, 5'h15);
      rd(0, 5'h0A);
      rd(37, 5'h15);

      // Full transfer
      @(negedge clk); xfer_start = 1'b1;
      run_xfer(0, 0, 5'h00, 0, 0);
      check("x1_nbits", ncap, 190);
      check("x1_first", {27'd0, grab(0)}, 32'h15);
      check("x1_pad36", {27'd0, grab(5)}, 32'h11);
      check("x1_last", {27'd0, grab(185)}, 32'h0A);
      check("x1_nload", nload, 2);
      check("x1_done_at", done_at, 763);
      check("x1_ndone", ndone, 1);
      check("x1_idle", {31'd0, xfer_busy}, 32'd0);

      // Write attempted while busy
      @(negedge clk); xfer_start = 1'b1;
      run_xfer(100, 37, 5'h00, 0, 0);
      check("x2_wr_err", nerr, 1);
      check("x2_first", {27'd0, grab(0)}, 32'h15);
      check("x2_nbits", ncap, 190);
      rd(37, 5'h15);

      // Write and start in the same cycle
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = 6'd5; cfg_wdata = 5'h03; xfer_start = 1'b1;
      run_xfer(0, 0, 5'h00, 0, 0);
      check("x3_pad5", {27'd0, grab(160)}, 32'h03);
      check("x3_nerr", nerr, 0);
      rd(5, 5'h03);

      // Start pulse while busy is ignored
      @(negedge clk); xfer_start = 1'b1;
      run_xfer(0, 0, 5'h00, 200, 0);
      check("x4_ndone", ndone, 1);
      check("x4_done_at", done_at, 763);
      check("x4_nbits", ncap, 190);
      check("x4_idle", {31'd0, xfer_busy}, 32'd0);

      // Reset mid-transfer
      @(negedge clk); xfer_start = 1'b1;
      run_xfer(0, 0, 5'h00, 0, 300);
      check("x5_sclk", {31'd0, rst_sclk}, 32'd0);
      check("x5_busy", {31'd0, rst_busy}, 32'd0);
      check("x5_nload", nload, 0);
      check("x5_ndone", ndone, 0);
      for (int a = 0; a < 38; a++) rd(a, 5'h11);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mprj_io_cfg_sequencer.md
MPRJ_IO_CFG_SEQUENCER -- requirements
Module: mprj_io_cfg_sequencer

Interface
REQ-001 SHALL have parameter TOTAL_PADS, default 38: number of user I/O pads in the configuration chain.
REQ-002 SHALL have parameter CFG_BITS, default 5: configuration bits per pad, encoded as {oeb, inp_dis, dm[2:0]}.
REQ-003 SHALL have parameter CLK_DIV, default 2, legal range 1..255: serial_clock half-period, in wb_clk_i cycles.
REQ-004 SHALL have port wb_clk_i, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-005 SHALL have port wb_rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port cfg_we, input, 1 bit: shadow-register write strobe.
REQ-007 SHALL have port cfg_addr, input, 6 bits: pad index for read and write.
REQ-008 SHALL have port cfg_wdata, input, CFG_BITS bits: write data.
REQ-009 SHALL have port cfg_rdata, output, CFG_BITS bits: combinational read of shadow[cfg_addr].
REQ-010 SHALL have port cfg_wr_err, output, 1 bit: one-cycle pulse when a write is rejected.
REQ-011 SHALL have port xfer_start, input, 1 bit: request to shift all shadows into the pad chain.
REQ-012 SHALL have port xfer_busy, output, 1 bit: high from the cycle after an accepted start until xfer_done, inclusive.
REQ-013 SHALL have port xfer_done, output, 1 bit: one-cycle completion pulse.
REQ-014 SHALL have port serial_clock, output, 1 bit: chain shift clock.
REQ-015 SHALL have port serial_data, output, 1 bit: chain data.
REQ-016 SHALL have port serial_load, output, 1 bit: chain parallel-load strobe.

Function
REQ-017 SHALL hold TOTAL_PADS shadow registers of CFG_BITS each, with reset value 5'b1_0_001 (oeb=1, inp_dis=0, dm=001, i.e. input-only).
REQ-018 SHALL, when IDLE with cfg_we=1 and cfg_addr<TOTAL_PADS, write cfg_wdata to shadow[cfg_addr] at the clock edge.
REQ-019 SHALL ignore a write with cfg_addr>=TOTAL_PADS, and return cfg_rdata=0 for that address; no error is flagged.
REQ-020 SHALL reject any cfg_we while xfer_busy=1, leave the shadow unchanged, and pulse cfg_wr_err=1 for the next cycle.
REQ-021 SHALL implement states IDLE, SHIFT_LO, SHIFT_HI, LOAD and DONE.
REQ-022 SHALL, in IDLE with xfer_start=1, load a bit counter with N=TOTAL_PADS*CFG_BITS, go to SHIFT_LO, and ignore xfer_start outside IDLE.
REQ-023 SHALL, when cfg_we and xfer_start arrive in the same IDLE cycle, apply the write first so the transfer shifts the new value.
REQ-024 SHALL shift in this order: pad TOTAL_PADS-1 first, down to pad 0, MSB first within each pad.
REQ-025 SHALL, in SHIFT_LO, hold serial_clock=0 for CLK_DIV cycles with serial_data already valid for the current bit, then go to SHIFT_HI.
REQ-026 SHALL, in SHIFT_HI, hold serial_clock=1 for CLK_DIV cycles, then decrement the counter and go to SHIFT_LO, or to LOAD when the counter reaches 0.
REQ-027 SHALL, in LOAD, hold serial_load=1 and serial_clock=0 for CLK_DIV cycles, then go to DONE.
REQ-028 SHALL, in DONE, hold xfer_done=1 for exactly one cycle, then return to IDLE.
REQ-029 SHALL keep serial_data stable for the whole of each SHIFT_LO+SHIFT_HI bit period.
REQ-030 SHALL assert xfer_done exactly N*2*CLK_DIV + CLK_DIV cycles after the first SHIFT_LO cycle; with defaults that is 762 cycles, or 763 from the start edge.
REQ-031 SHALL drive serial_clock=0, serial_data=0 and serial_load=0 in IDLE and DONE.
REQ-032 SHALL size the counter and the divider to hold N and CLK_DIV without wrap-around.
REQ-033 SHALL read shadows during a transfer; they cannot change mid-transfer because REQ-020 locks them.

Reset
REQ-034 SHALL, with wb_rst_i=1 at a clock edge, enter IDLE and restore every shadow to its reset value.
REQ-035 SHALL, during reset, drive all outputs to 0, except cfg_rdata, which reflects the shadows.
REQ-036 SHALL, on reset during a transfer, abort it with no xfer_done and no serial_load pulse; serial_clock=0 in the next cycle.

Verification
REQ-037 Scenario: after reset, read addresses 0..37 -> cfg_rdata=5'h11 at each; read address 40 -> cfg_rdata=0.
REQ-038 Scenario: write pad0=5'h0A and pad37=5'h15, then xfer_start -> the bench chain model captures 190 bits in order; the first 5 bits are 10101 and the last 5 are 01010; serial_load is high for 2 cycles; xfer_done rises 763 cycles after the start edge.
REQ-039 Scenario: cfg_we during busy -> cfg_wr_err pulses for 1 cycle, the shadow is unchanged, and the transfer data is unaffected.
REQ-040 Scenario: cfg_we to pad5=5'h03 and xfer_start in the same IDLE cycle -> the shifted bits for pad5 are 00011.
REQ-041 Scenario: xfer_start pulsed during busy -> no restart, and exactly one xfer_done.
REQ-042 Scenario: wb_rst_i asserted at cycle 300 of a transfer -> serial_clock=0 and xfer_busy=0 the next cycle, no serial_load, and shadows=5'h11.
